// File: rtl/lab9_soc_pio_pkg.sv
// Shared definitions for the lab9 SoC extended PIO: register word indices
// and the encodings accepted by the EDGE_TYPE and IRQ_MODE parameters.
package lab9_soc_pio_pkg;

    // Register word indices on the Avalon-MM address bus
    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    // Edge that sets a capture bit
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Interrupt generation mode
    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/lab9_soc_pio_sync.sv
// Multi-stage synchroniser for asynchronous pin inputs. Every stage clears
// to zero on the synchronous active-low reset.
module lab9_soc_pio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // Shift the pin values through the synchroniser chain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/lab9_soc_pio_ext.sv
// Parametrised Avalon-MM GPIO port: per-bit direction, synchronised inputs,
// edge capture with masked interrupt, and atomic set/clear of output bits.
// Zero-wait-state slave with combinational read data.
module lab9_soc_pio_ext
    import lab9_soc_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               IRQ_MODE    = IRQ_EDGE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_q,    data_d;
    logic [WIDTH-1:0] dir_q,     dir_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] sync_d_q;

    logic             wr_s;
    logic [WIDTH-1:0] wd_s;
    logic [WIDTH-1:0] sync_in_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] rd_s;
    logic [31:0]      rd32_s;
    logic             unused_wd_s;

    assign wr_s = chipselect & ~write_n;
    assign wd_s = writedata[WIDTH-1:0];
    // Upper write-data bits are intentionally dropped for narrow ports
    assign unused_wd_s = ^writedata;

    lab9_soc_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_port),
        .q_o     (sync_in_s)
    );

    assign rise_s = sync_in_s & ~sync_d_q;
    assign fall_s = ~sync_in_s & sync_d_q;

    // Select the edge kind that arms a capture bit; only input bits capture
    always_comb begin
        edge_s = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_s = rise_s;
            EDGE_FALL: edge_s = fall_s;
            EDGE_ANY:  edge_s = rise_s | fall_s;
            default:   edge_s = rise_s;
        endcase
        edge_s = edge_s & ~dir_q;
    end

    // Next-state for the software-visible registers from the current bus write
    always_comb begin
        data_d    = data_q;
        dir_d     = dir_q;
        irqmask_d = irqmask_q;
        clr_s     = '0;
        if (wr_s) begin
            case (address)
                ADDR_DATA:    data_d    = wd_s;
                ADDR_DIR:     dir_d     = wd_s;
                ADDR_IRQMASK: irqmask_d = wd_s;
                ADDR_EDGECAP: clr_s     = wd_s;
                ADDR_OUTSET:  data_d    = data_q | wd_s;
                ADDR_OUTCLR:  data_d    = data_q & ~wd_s;
                default:      data_d    = data_q;
            endcase
        end else begin
            clr_s = '0;
        end
        // A fresh edge overrides a clear hitting the same bit
        edgecap_d = (edgecap_q & ~clr_s) | edge_s;
    end

    // Register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q    <= RESET_VALUE;
            dir_q     <= RESET_DIR;
            irqmask_q <= '0;
            edgecap_q <= '0;
            sync_d_q  <= '0;
        end else begin
            data_q    <= data_d;
            dir_q     <= dir_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            sync_d_q  <= sync_in_s;
        end
    end

    // Combinational read mux; unmapped words and write-only words read zero
    always_comb begin
        rd_s = '0;
        case (address)
            ADDR_DATA:    rd_s = (sync_in_s & ~dir_q) | (data_q & dir_q);
            ADDR_DIR:     rd_s = dir_q;
            ADDR_IRQMASK: rd_s = irqmask_q;
            ADDR_EDGECAP: rd_s = edgecap_q;
            default:      rd_s = '0;
        endcase
        rd32_s            = 32'h0000_0000;
        rd32_s[WIDTH-1:0] = rd_s;
    end

    assign readdata = rd32_s;
    assign out_port = data_q;
    assign oe       = dir_q;

    generate
        if (IRQ_MODE == IRQ_LEVEL) begin : g_irq_level
            assign irq = |(sync_in_s & ~dir_q & irqmask_q);
        end else begin : g_irq_edge
            assign irq = |(edgecap_q & irqmask_q);
        end
    endgenerate

endmodule

// File: tb/tb_lab9_soc_pio_ext.sv
// Directed self-checking bench for lab9_soc_pio_ext (WIDTH=8, rising edge,
// edge-sensitive irq, two-stage synchroniser). Inputs change on the falling
// clock edge; outputs are sampled in the low phase, away from the rising edge.
module tb_lab9_soc_pio_ext;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rdv;

    lab9_soc_pio_ext #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .RESET_DIR   (8'hFF),
        .EDGE_TYPE   (0),
        .IRQ_MODE    (1),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; returns at the next falling edge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (out_port !== 8'hA5) begin miscompares++; $display("FAIL reset_out_port: got %h want a5", out_port); end
        vectors++;
        if (oe !== 8'hFF) begin miscompares++; $display("FAIL reset_oe: got %h want ff", oe); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", irq); end
        rd(3'd3, rdv);
        vectors++;
        if (rdv !== 32'h0) begin miscompares++; $display("FAIL reset_edgecap: got %h want 0", rdv); end
        rd(3'd2, rdv);
        vectors++;
        if (rdv !== 32'h0) begin miscompares++; $display("FAIL reset_irqmask: got %h want 0", rdv); end
        // A write during reset must be discarded
        wr(3'd0, 32'h0000_0011);
        vectors++;
        if (out_port !== 8'hA5) begin miscompares++; $display("FAIL reset_write_ignored: got %h want a5", out_port); end
        reset_n = 1'b1;
    endtask

    task automatic test_set_clear();
        wr(3'd0, 32'h0000_000F);
        vectors++;
        if (out_port !== 8'h0F) begin miscompares++; $display("FAIL data_write: got %h want 0f", out_port); end
        wr(3'd4, 32'h0000_00F0);
        vectors++;
        if (out_port !== 8'hFF) begin miscompares++; $display("FAIL outset: got %h want ff", out_port); end
        wr(3'd5, 32'h0000_0081);
        vectors++;
        if (out_port !== 8'h7E) begin miscompares++; $display("FAIL outclr: got %h want 7e", out_port); end
        rd(3'd0, rdv);
        vectors++;
        if (rdv !== 32'h0000_007E) begin miscompares++; $display("FAIL data_read_out: got %h want 7e", rdv); end
    endtask

    task automatic test_mixed_dir();
        wr(3'd1, 32'h0000_00F0);
        wr(3'd0, 32'h0000_00A0);
        in_port = 8'h05;
        @(negedge clk);
        rd(3'd0, rdv);
        vectors++;
        if (rdv !== 32'h0000_00A0) begin miscompares++; $display("FAIL mixed_one_cycle: got %h want a0", rdv); end
        @(negedge clk);
        rd(3'd0, rdv);
        vectors++;
        if (rdv !== 32'h0000_00A5) begin miscompares++; $display("FAIL mixed_two_cycles: got %h want a5", rdv); end
        @(negedge clk);
        rd(3'd3, rdv);
        vectors++;
        if (rdv !== 32'h0000_0005) begin miscompares++; $display("FAIL mixed_edgecap: got %h want 05", rdv); end
        wr(3'd3, 32'h0000_00FF);
        rd(3'd3, rdv);
        vectors++;
        if (rdv !== 32'h0) begin miscompares++; $display("FAIL mixed_clear: got %h want 0", rdv); end
    endtask

    task automatic test_rise_irq();
        wr(3'd1, 32'h0000_0000);
        wr(3'd2, 32'h0000_0001);
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        rd(3'd3, rdv);
        vectors++;
        if (rdv !== 32'h0) begin miscompares++; $display("FAIL falling_ignored: got %h want 0", rdv); end
        in_port = 8'h01;
        repeat (2) @(negedge clk);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early: got %b want 0", irq); end
        @(negedge clk);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_three_cycles: got %b want 1", irq); end
        rd(3'd3, rdv);
        vectors++;
        if (rdv !== 32'h0000_0001) begin miscompares++; $display("FAIL edgecap_bit0: got %h want 01", rdv); end
        wr(3'd3, 32'h0000_0001);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_cleared: got %b want 0", irq); end
    endtask

    task automatic test_collision();
        in_port = 8'h05;
        repeat (2) @(negedge clk);
        wr(3'd3, 32'h0000_0004);
        rd(3'd3, rdv);
        vectors++;
        if (rdv !== 32'h0000_0004) begin miscompares++; $display("FAIL edge_wins_clear: got %h want 04", rdv); end
        wr(3'd3, 32'h0000_0004);
        rd(3'd3, rdv);
        vectors++;
        if (rdv !== 32'h0) begin miscompares++; $display("FAIL bit2_cleared: got %h want 0", rdv); end
        wr(3'd1, 32'h0000_0010);
        in_port = 8'h15;
        repeat (4) @(negedge clk);
        rd(3'd3, rdv);
        vectors++;
        if (rdv !== 32'h0) begin miscompares++; $display("FAIL output_bit_no_capture: got %h want 0", rdv); end
        wr(3'd1, 32'h0000_0000);
    endtask

    task automatic test_mask_unused();
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        wr(3'd3, 32'h0000_00FF);
        in_port = 8'hFF;
        repeat (3) @(negedge clk);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_all_edges: got %b want 1", irq); end
        wr(3'd2, 32'h0000_0000);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_masked: got %b want 0", irq); end
        rd(3'd3, rdv);
        vectors++;
        if (rdv !== 32'h0000_00FF) begin miscompares++; $display("FAIL pending_edges: got %h want ff", rdv); end
        wr(3'd6, 32'hFFFF_FFFF);
        vectors++;
        if (out_port !== 8'hA0) begin miscompares++; $display("FAIL addr6_out_port: got %h want a0", out_port); end
        vectors++;
        if (oe !== 8'h00) begin miscompares++; $display("FAIL addr6_oe: got %h want 00", oe); end
        rd(3'd2, rdv);
        vectors++;
        if (rdv !== 32'h0) begin miscompares++; $display("FAIL addr6_irqmask: got %h want 0", rdv); end
        rd(3'd6, rdv);
        vectors++;
        if (rdv !== 32'h0) begin miscompares++; $display("FAIL addr6_read: got %h want 0", rdv); end
        rd(3'd7, rdv);
        vectors++;
        if (rdv !== 32'h0) begin miscompares++; $display("FAIL addr7_read: got %h want 0", rdv); end
        wr(3'd1, 32'h0000_00FF);
        rd(3'd3, rdv);
        vectors++;
        if (rdv !== 32'h0000_00FF) begin miscompares++; $display("FAIL dir_keeps_edgecap: got %h want ff", rdv); end
        wr(3'd0, 32'h1234_5678);
        vectors++;
        if (out_port !== 8'h78) begin miscompares++; $display("FAIL wide_write: got %h want 78", out_port); end
        rd(3'd0, rdv);
        vectors++;
        if (rdv !== 32'h0000_0078) begin miscompares++; $display("FAIL wide_read: got %h want 00000078", rdv); end
        rd(3'd4, rdv);
        vectors++;
        if (rdv !== 32'h0) begin miscompares++; $display("FAIL outset_reads_zero: got %h want 0", rdv); end
    endtask

    task automatic test_back_to_back();
        wr(3'd4, 32'h0000_0080);
        wr(3'd5, 32'h0000_0008);
        vectors++;
        if (out_port !== 8'hF0) begin miscompares++; $display("FAIL back_to_back: got %h want f0", out_port); end
        rd(3'd5, rdv);
        vectors++;
        if (rdv !== 32'h0) begin miscompares++; $display("FAIL outclr_reads_zero: got %h want 0", rdv); end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        @(negedge clk);
        test_reset();
        test_set_clear();
        test_mixed_dir();
        test_rise_irq();
        test_collision();
        test_mask_unused();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
